// File: rtl/prior_arbiter_pkg.sv
// Shared types and constants for the registered priority arbiter with seven-segment readout.
// Digit slots map arbiter state onto the 8-digit display bank.
package prior_arbiter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam int DIGITS = 8;
    localparam int CNT_W  = 8;

    localparam int IDX_LO = 0;
    localparam int IDX_HI = 1;
    localparam int CNT_LO = 6;
    localparam int CNT_HI = 7;

endpackage

// File: rtl/prior_arbiter_seg_pick.sv
// Wrap-around priority scan: from start (or N-1 when rr=0) downward, wrapping to N-1.
// Combinational, zero latency; found=0 when nothing is pending.
module prior_pick #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] start,
    input  logic             rr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin : scan
        int s;
        int p;
        idx   = '0;
        found = 1'b0;
        s     = rr ? int'(start) : N - 1;
        p     = 0;
        // k is the distance from the start slot; the first hit is the highest priority
        for (int k = 0; k < N; k++) begin
            p = (s >= k) ? (s - k) : (s + N - k);
            if (!found && pending[p]) begin
                idx   = IDX_W'(p);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg.sv
// Hex nibble to seven-segment code {dp,g,f,e,d,c,b,a}, active-high; blank when disabled.
// Purely combinational, no flow control.
module seg (
    input  logic [3:0] in,
    input  logic       en,
    output logic [7:0] out
);

    always_comb begin
        out = 8'h00;
        if (en) begin
            case (in)
                4'h0: out = 8'h3F;
                4'h1: out = 8'h06;
                4'h2: out = 8'h5B;
                4'h3: out = 8'h4F;
                4'h4: out = 8'h66;
                4'h5: out = 8'h6D;
                4'h6: out = 8'h7D;
                4'h7: out = 8'h07;
                4'h8: out = 8'h7F;
                4'h9: out = 8'h6F;
                4'hA: out = 8'h77;
                4'hB: out = 8'h7C;
                4'hC: out = 8'h39;
                4'hD: out = 8'h5E;
                4'hE: out = 8'h79;
                default: out = 8'h71;
            endcase
        end
    end

endmodule

// File: rtl/prior_arbiter_seg.sv
// Sticky-request arbiter: req->out_valid 2 edges, one grant per 2 cycles, index held until out_ready.
// Backpressure: out_idx frozen while out_valid && !out_ready; new requests only accumulate in pending.
module prior_arbiter_seg
    import prior_arbiter_pkg::*;
#(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             rr_mode,
    input  logic             en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             flag,
    output logic [N-1:0]     pending,
    output logic [7:0]       seg_out [DIGITS-1:0]
);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   last_idx;
    logic               has_last;
    logic [CNT_W-1:0]   grant_cnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               accept;
    logic [N-1:0]       clr_mask;
    logic [N-1:0]       pending_nxt;
    logic [7:0]         idx_ext;
    logic [3:0]         digit_in [DIGITS];
    logic               digit_en [DIGITS];

    prior_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending (pending),
        .start   (ptr),
        .rr      (rr_mode),
        .idx     (pick_idx),
        .found   (pick_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found) state_nxt = PRESENT;
            PRESENT: if (out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == PRESENT);
        accept    = out_valid && out_ready;
        clr_mask  = '0;
        if (accept) begin
            clr_mask[out_idx] = 1'b1;
        end
        // a request landing on the index being cleared keeps the bit set
        pending_nxt = (pending & ~clr_mask) | req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            flag      <= 1'b0;
            out_idx   <= '0;
            ptr       <= IDX_W'(N - 1);
            last_idx  <= '0;
            has_last  <= 1'b0;
            grant_cnt <= '0;
        end else begin
            pending <= pending_nxt;
            flag    <= |pending_nxt;
            if (state == IDLE && pick_found) begin
                out_idx <= pick_idx;
            end
            if (accept) begin
                last_idx  <= out_idx;
                has_last  <= 1'b1;
                grant_cnt <= grant_cnt + 1'b1;
                if (rr_mode) begin
                    ptr <= (out_idx == '0) ? IDX_W'(N - 1) : out_idx - 1'b1;
                end else begin
                    ptr <= IDX_W'(N - 1);
                end
            end
        end
    end

    assign idx_ext = 8'(last_idx);

    always_comb begin
        for (int d = 0; d < DIGITS; d++) begin
            digit_in[d] = 4'h0;
            digit_en[d] = 1'b0;
        end
        digit_in[IDX_LO] = idx_ext[3:0];
        digit_en[IDX_LO] = en && has_last;
        digit_in[IDX_HI] = idx_ext[7:4];
        digit_en[IDX_HI] = en && has_last && (IDX_W > 4);
        digit_in[CNT_LO] = grant_cnt[3:0];
        digit_en[CNT_LO] = en;
        digit_in[CNT_HI] = grant_cnt[7:4];
        digit_en[CNT_HI] = en;
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_seg
        seg u_seg (
            .in  (digit_in[d]),
            .en  (digit_en[d]),
            .out (seg_out[d])
        );
    end

endmodule
